run_sequencer: RTL and testbench
================================

Name: run_sequencer

Overview:
- Run-control sequencer for the single-cycle CPU.
- Converts the front-panel buttons (run, pause, Continue, step) and the speed switch into a one-cycle instruction-commit enable, `cpu_en`.
- `cpu_en` gates PC update, register-file writes and memory writes.
- Enforces syscall halt (`STOP`), a PC breakpoint, and an instruction counter.
- Sits between the board inputs and the datapath, with every register on `CLK`.

Parameters:
- DEB_CYC, 20'd1000000: cycles a synchronized button level must stay stable before it is accepted.
- SLOW_DIV, 26'd50000000: `CLK` cycles per instruction when `adjust`=0.
- FAST_DIV, 26'd5000000: `CLK` cycles per instruction when `adjust`=1.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous, active-low reset.
- run  in  1  raw button: start free-running execution.
- pause  in  1  raw button: suspend execution.
- Continue  in  1  raw button: resume after pause or breakpoint.
- step  in  1  raw button: execute exactly one instruction while paused or idle.
- adjust  in  1  speed select (level; synchronized, not debounced).
- STOP  in  1  halt request from control, combinational for the current instruction.
- bp_en  in  1  breakpoint enable.
- bp_addr  in  32  breakpoint PC.
- PC  in  32  current PC.
- cpu_en  out  1  one-cycle commit enable.
- state  out  2  00 IDLE, 01 RUN, 10 PAUSE, 11 HALT.
- halted  out  1  high when `state`==HALT.
- bp_hit  out  1  high while paused by the breakpoint.
- cycles  out  32  committed-instruction count.

Behaviour:
- Reset (`RST`=0, async): state=IDLE; `cpu_en`=0, `halted`=0, `bp_hit`=0, `cycles`=0; prescaler, debouncers and skip flag cleared.
- Button inputs:
  - Each button passes through a 2-FF synchronizer, then a debouncer.
  - The debouncer updates its accepted level after DEB_CYC consecutive equal samples.
  - A 0→1 change of the accepted level produces a one-cycle event.
  - Event-to-state latency: DEB_CYC+3 cycles after the raw edge.
- Event priority within one cycle: pause > Continue > run > step. Lower-priority events in that cycle are discarded.
- Prescaler:
  - Counts 0..LIM-1, where LIM = `adjust` ? FAST_DIV : SLOW_DIV, sampled every cycle.
  - `tick`=1 when count==LIM-1; the count then wraps to 0.
  - Count is forced to 0 on any entry to RUN.
  - If `adjust` changes and the count is ≥ the new LIM-1, `tick` fires next cycle and the count wraps.
- Transitions:
  - IDLE: run→RUN; step→one-shot (see below), stay IDLE.
  - RUN:
    - pause→PAUSE.
    - On `tick`, checked in priority order:
      - `STOP`=1 → HALT, no `cpu_en`.
      - `bp_en` && `PC`==`bp_addr` && !skip → PAUSE with `bp_hit`=1, no `cpu_en`.
      - otherwise `cpu_en`=1 and skip cleared.
  - PAUSE:
    - Continue or run → RUN; skip=1, `bp_hit`=0.
    - step → one-shot, stay PAUSE; skip cleared after the commit.
  - HALT: absorbing; only `RST` leaves it. All events ignored.
- One-shot step:
  - `cpu_en` is asserted in the cycle after the step event unless `STOP`=1.
  - If `STOP`=1, state goes to HALT and `cpu_en` stays 0.
  - A step never stops on the breakpoint.
- Skip flag: guarantees that resuming at the breakpoint PC commits that instruction once instead of re-trapping.
- `cpu_en`:
  - Never high for two consecutive cycles.
  - Never high in HALT.
  - Registered output: high in the cycle after the `tick` or step event is detected.
- `cycles`: +1 per `cpu_en`; saturates at 32'hFFFFFFFF, never wraps.
- Reset mid-operation: every register returns to its reset value immediately, including a pending `cpu_en`, prescaler and debouncer state.

Test Plan:
- Bench parameters: DEB_CYC=4, SLOW_DIV=8, FAST_DIV=2.
1. Reset, then a clean run press (held 10 cycles), `STOP`=0, `bp_en`=0 → state=01 at 7 cycles after the edge; `cpu_en` pulses every 8 cycles; `cycles`=5 after 5 pulses; `adjust`=1 → pulses every 2 cycles.
2. Run press bouncing 0/1 every 2 cycles for 12 cycles, then stable high → exactly one run event; state stays IDLE during the bounce.
3. RUN with `bp_en`=1, `bp_addr`=32'h0000_0010, `PC` stepping by 4 on each `cpu_en` from 0 → 4 pulses, then state=10, `bp_hit`=1 at PC 0x10. Continue → the next `tick` commits at 0x10 (`cpu_en`=1), RUN continues.
4. PAUSE, then step presses ×3 → exactly 3 `cpu_en` pulses and `cycles`+3; state remains 10. Pause and run asserted on the same cycle → PAUSE wins.
5. RUN, `STOP` raised → at the next `tick` state=11, `halted`=1, no `cpu_en`. Subsequent run, Continue and step presses → no change. `RST` low → state=00, `cycles`=0 asynchronously.
6. Force `cycles` to 32'hFFFFFFFE via a bench-forced path, then 3 commits → `cycles`=32'hFFFFFFFF and holds.

Source files
------------

// File: rtl/run_sequencer.sv
// run_sequencer: run-control sequencer for the single-cycle CPU.
// Turns the front-panel buttons and the speed switch into a one-cycle
// instruction-commit enable, and enforces syscall halt, a PC breakpoint
// and a saturating committed-instruction counter.
// Ports:
//   CLK, RST                    clock, asynchronous active-low reset
//   run, pause, Continue, step  raw buttons (synchronized + debounced)
//   adjust                      speed select (synchronized level)
//   STOP                        halt request for the current instruction
//   bp_en, bp_addr, PC          breakpoint enable, breakpoint PC, current PC
//   cpu_en                      one-cycle commit enable
//   state                       00 IDLE, 01 RUN, 10 PAUSE, 11 HALT
//   halted, bp_hit              HALT flag, paused-at-breakpoint flag
//   cycles                      committed-instruction count (saturating)
module run_sequencer #(
  parameter logic [19:0] DEB_CYC  = 20'd1000000,
  parameter logic [25:0] SLOW_DIV = 26'd50000000,
  parameter logic [25:0] FAST_DIV = 26'd5000000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        run,
  input  logic        pause,
  input  logic        Continue,
  input  logic        step,
  input  logic        adjust,
  input  logic        STOP,
  input  logic        bp_en,
  input  logic [31:0] bp_addr,
  input  logic [31:0] PC,
  output logic        cpu_en,
  output logic [1:0]  state,
  output logic        halted,
  output logic        bp_hit,
  output logic [31:0] cycles
);

  localparam int unsigned DEB_W = 20;
  localparam int unsigned DIV_W = 26;
  localparam int unsigned CNT_W = 32;
  localparam int unsigned BTN_N = 4;
  // Button bit positions, also the event priority order (lowest index wins).
  localparam int unsigned B_PAUSE = 0;
  localparam int unsigned B_CONT  = 1;
  localparam int unsigned B_RUN   = 2;
  localparam int unsigned B_STEP  = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_HALT  = 2'b11
  } state_t;

  state_t             state_q;
  logic [BTN_N-1:0]   btn_raw_c;
  logic [BTN_N-1:0]   sync1;
  logic [BTN_N-1:0]   sync2;
  logic [BTN_N-1:0]   stable;
  logic [BTN_N-1:0]   stable_d;
  logic [DEB_W-1:0]   deb_cnt [BTN_N];
  logic               adj_s1;
  logic               adj_s2;
  logic [DIV_W-1:0]   pcnt;
  logic               skip;

  logic [BTN_N-1:0]   rise_c;
  logic               ev_pause_c;
  logic               ev_cont_c;
  logic               ev_run_c;
  logic               ev_step_c;
  logic [DIV_W-1:0]   lim_c;
  logic               tick_c;
  logic               bp_match_c;

  assign btn_raw_c = {step, run, Continue, pause};
  assign state     = state_q;

  // Single-cycle events from rising accepted levels, priority-resolved.
  assign rise_c     = stable & ~stable_d;
  assign ev_pause_c = rise_c[B_PAUSE];
  assign ev_cont_c  = rise_c[B_CONT] & ~rise_c[B_PAUSE];
  assign ev_run_c   = rise_c[B_RUN] & ~rise_c[B_CONT] & ~rise_c[B_PAUSE];
  assign ev_step_c  = rise_c[B_STEP] & ~rise_c[B_RUN] & ~rise_c[B_CONT] & ~rise_c[B_PAUSE];

  // Compare >= so a shrinking limit after a speed change still ticks and wraps.
  assign lim_c      = adj_s2 ? FAST_DIV : SLOW_DIV;
  assign tick_c     = (pcnt >= (lim_c - DIV_W'(1)));
  assign bp_match_c = bp_en && (PC == bp_addr);

  // Synchronizers and per-button debouncers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync1    <= '0;
      sync2    <= '0;
      stable   <= '0;
      stable_d <= '0;
      adj_s1   <= 1'b0;
      adj_s2   <= 1'b0;
      for (int i = 0; i < int'(BTN_N); i++) deb_cnt[i] <= '0;
    end else begin
      sync1    <= btn_raw_c;
      sync2    <= sync1;
      stable_d <= stable;
      adj_s1   <= adjust;
      adj_s2   <= adj_s1;
      for (int i = 0; i < int'(BTN_N); i++) begin
        if (sync2[i] != stable[i]) begin
          if (deb_cnt[i] == (DEB_CYC - DEB_W'(1))) begin
            stable[i]  <= sync2[i];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

  // Run-control FSM, prescaler, skip flag and commit counter.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      cpu_en  <= 1'b0;
      halted  <= 1'b0;
      bp_hit  <= 1'b0;
      cycles  <= '0;
      pcnt    <= '0;
      skip    <= 1'b0;
    end else begin
      cpu_en <= 1'b0;
      pcnt   <= tick_c ? '0 : pcnt + DIV_W'(1);
      if (cpu_en && (cycles != '1)) cycles <= cycles + CNT_W'(1);

      case (state_q)
        ST_IDLE: begin
          if (ev_run_c) begin
            state_q <= ST_RUN;
            pcnt    <= '0;
          end else if (ev_step_c) begin
            if (STOP) begin
              state_q <= ST_HALT;
              halted  <= 1'b1;
            end else begin
              cpu_en <= 1'b1;
              skip   <= 1'b0;
            end
          end
        end
        ST_RUN: begin
          if (ev_pause_c) begin
            state_q <= ST_PAUSE;
          end else if (tick_c) begin
            if (STOP) begin
              state_q <= ST_HALT;
              halted  <= 1'b1;
            end else if (bp_match_c && !skip) begin
              state_q <= ST_PAUSE;
              bp_hit  <= 1'b1;
            end else if (!cpu_en) begin
              // Guard keeps commits non-adjacent even with a 1-cycle limit.
              cpu_en <= 1'b1;
              skip   <= 1'b0;
            end
          end
        end
        ST_PAUSE: begin
          if (ev_cont_c || ev_run_c) begin
            // skip lets the instruction at the breakpoint PC commit once.
            state_q <= ST_RUN;
            skip    <= 1'b1;
            bp_hit  <= 1'b0;
            pcnt    <= '0;
          end else if (ev_step_c) begin
            if (STOP) begin
              state_q <= ST_HALT;
              halted  <= 1'b1;
              bp_hit  <= 1'b0;
            end else begin
              cpu_en <= 1'b1;
              skip   <= 1'b0;
            end
          end
        end
        ST_HALT: begin
          state_q <= ST_HALT;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_run_sequencer.sv
// tb_run_sequencer: scoreboard bench for run_sequencer with short debounce
// and prescaler limits. Stimulus pushes expected commits (PC and spacing);
// a monitor pops one entry per cpu_en pulse and compares.
module tb_run_sequencer;

  localparam logic [19:0] DEB  = 20'd4;
  localparam logic [25:0] SLOW = 26'd8;
  localparam logic [25:0] FAST = 26'd2;

  localparam int B_PAUSE = 0;
  localparam int B_CONT  = 1;
  localparam int B_RUN   = 2;
  localparam int B_STEP  = 3;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        run = 1'b0;
  logic        pause = 1'b0;
  logic        Continue = 1'b0;
  logic        step = 1'b0;
  logic        adjust = 1'b0;
  logic        STOP = 1'b0;
  logic        bp_en = 1'b0;
  logic [31:0] bp_addr = 32'h0;
  logic [31:0] PC;
  logic        cpu_en;
  logic [1:0]  state;
  logic        halted;
  logic        bp_hit;
  logic [31:0] cycles;

  typedef struct {
    logic [31:0] pc;
    int unsigned gap;   // cycles since previous commit; 0 = not checked
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          errors = 0;
  int          checks = 0;
  int unsigned cyc = 0;
  int unsigned last_en = 0;
  logic [31:0] pc_model;

  run_sequencer #(
    .DEB_CYC (DEB),
    .SLOW_DIV(SLOW),
    .FAST_DIV(FAST)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .run     (run),
    .pause   (pause),
    .Continue(Continue),
    .step    (step),
    .adjust  (adjust),
    .STOP    (STOP),
    .bp_en   (bp_en),
    .bp_addr (bp_addr),
    .PC      (PC),
    .cpu_en  (cpu_en),
    .state   (state),
    .halted  (halted),
    .bp_hit  (bp_hit),
    .cycles  (cycles)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Datapath stand-in: PC advances by 4 on every commit.
  always @(posedge CLK or negedge RST) begin
    if (!RST) pc_model <= 32'h0;
    else if (cpu_en) pc_model <= pc_model + 32'd4;
  end
  assign PC = pc_model;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: one scoreboard entry per commit pulse.
  always @(negedge CLK) begin
    if (RST && cpu_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_commit: got cpu_en at pc %h expected none", PC);
      end else begin
        mon_e = exp_q.pop_front();
        chk("commit_pc", PC, mon_e.pc);
        if (mon_e.gap != 0) chk("commit_gap", 32'(cyc - last_en), 32'(mon_e.gap));
      end
      last_en = cyc;
    end
  end

  task automatic ticks(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic push(input logic [31:0] pc, input int unsigned gap);
    exp_t e;
    e.pc  = pc;
    e.gap = gap;
    exp_q.push_back(e);
  endtask

  task automatic drive(input int b, input logic v);
    case (b)
      B_PAUSE: pause = v;
      B_CONT:  Continue = v;
      B_RUN:   run = v;
      default: step = v;
    endcase
  endtask

  // Clean press: held 10 cycles, then low long enough to debounce back.
  task automatic press(input int b);
    drive(b, 1'b1);
    ticks(10);
    drive(b, 1'b0);
    ticks(10);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge CLK);
      #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d commits missing expected 0 after %0d cycles", exp_q.size(), budget);
      exp_q.delete();
    end
  endtask

  task automatic wait_state(input logic [1:0] s, input int budget, input string name);
    int n = 0;
    while (state !== s && n < budget) begin
      @(negedge CLK);
      #1;
      n++;
    end
    chk(name, 32'(state), 32'(s));
  endtask

  // Asynchronous reset from the current time point; outputs checked before any clock edge.
  task automatic do_reset();
    run = 1'b0; pause = 1'b0; Continue = 1'b0; step = 1'b0;
    adjust = 1'b0; STOP = 1'b0; bp_en = 1'b0; bp_addr = 32'h0;
    RST = 1'b0;
    #1;
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_cycles", cycles, 32'd0);
    chk("reset_cpu_en", 32'(cpu_en), 32'd0);
    chk("reset_halted", 32'(halted), 32'd0);
    chk("reset_bp_hit", 32'(bp_hit), 32'd0);
    exp_q.delete();
    ticks(2);
    RST = 1'b1;
  endtask

  initial begin
    #2;
    do_reset();

    // 1: clean run press, slow then fast rate.
    run = 1'b1;
    ticks(6);
    chk("t1_idle_at_6", 32'(state), 32'd0);
    ticks(1);
    chk("t1_run_at_7", 32'(state), 32'd1);
    push(32'h0, 0); push(32'h4, 8); push(32'h8, 8); push(32'hC, 8); push(32'h10, 8);
    ticks(3);
    run = 1'b0;
    wait_drain(60);
    @(negedge CLK);
    chk("t1_cycles5", cycles, 32'd5);
    adjust = 1'b1;
    push(32'h14, 4); push(32'h18, 2); push(32'h1C, 2);
    wait_drain(30);
    @(negedge CLK);
    chk("t1_cycles8", cycles, 32'd8);
    do_reset();

    // 2: bouncing run press gives a single event once stable.
    for (int k = 0; k < 6; k++) begin
      run = (k % 2 == 0);
      ticks(2);
      chk("t2_idle_bounce", 32'(state), 32'd0);
    end
    run = 1'b1;
    ticks(6);
    chk("t2_idle_at_6", 32'(state), 32'd0);
    ticks(1);
    chk("t2_run_at_7", 32'(state), 32'd1);
    ticks(2);
    do_reset();

    // 3: breakpoint trap at 0x10, Continue commits it once.
    bp_en = 1'b1;
    bp_addr = 32'h10;
    push(32'h0, 0); push(32'h4, 8); push(32'h8, 8); push(32'hC, 8);
    run = 1'b1;
    ticks(10);
    run = 1'b0;
    wait_drain(60);
    wait_state(2'b10, 20, "t3_bp_pause");
    chk("t3_bp_hit", 32'(bp_hit), 32'd1);
    chk("t3_pc_at_bp", PC, 32'h10);
    chk("t3_cycles4", cycles, 32'd4);
    push(32'h10, 0); push(32'h14, 8);
    press(B_CONT);
    wait_drain(60);
    chk("t3_resumed", 32'(state), 32'd1);
    chk("t3_bp_clear", 32'(bp_hit), 32'd0);
    do_reset();

    // 4: manual pause, three steps, pause beats run in one cycle.
    run = 1'b1;
    ticks(7);
    chk("t4_run", 32'(state), 32'd1);
    pause = 1'b1;
    ticks(6);
    chk("t4_run_before_pause", 32'(state), 32'd1);
    ticks(1);
    chk("t4_paused", 32'(state), 32'd2);
    run = 1'b0;
    pause = 1'b0;
    ticks(10);
    chk("t4_no_bp_hit", 32'(bp_hit), 32'd0);
    for (int k = 0; k < 3; k++) begin
      push(32'(4 * k), 0);
      press(B_STEP);
    end
    wait_drain(5);
    chk("t4_cycles3", cycles, 32'd3);
    chk("t4_still_paused", 32'(state), 32'd2);
    run = 1'b1;
    pause = 1'b1;
    ticks(10);
    run = 1'b0;
    pause = 1'b0;
    ticks(10);
    chk("t4_pause_wins", 32'(state), 32'd2);
    do_reset();

    // 5: STOP halts at the next tick; HALT ignores all buttons.
    push(32'h0, 0);
    run = 1'b1;
    ticks(10);
    run = 1'b0;
    wait_drain(40);
    STOP = 1'b1;
    wait_state(2'b11, 20, "t5_halt");
    chk("t5_halted", 32'(halted), 32'd1);
    press(B_RUN);
    press(B_CONT);
    press(B_STEP);
    chk("t5_halt_absorbing", 32'(state), 32'd3);
    chk("t5_cycles1", cycles, 32'd1);
    do_reset();

    // 5b: step with STOP halts without a commit.
    STOP = 1'b1;
    press(B_STEP);
    chk("t5b_step_halt", 32'(state), 32'd3);
    chk("t5b_halted", 32'(halted), 32'd1);
    chk("t5b_cycles0", cycles, 32'd0);
    do_reset();

    // 6: counter saturates at all-ones.
    @(negedge CLK);
    force dut.cycles = 32'hFFFF_FFFE;
    @(negedge CLK);
    release dut.cycles;
    @(negedge CLK);
    chk("t6_preload", cycles, 32'hFFFF_FFFE);
    for (int k = 0; k < 3; k++) begin
      push(32'(4 * k), 0);
      press(B_STEP);
      chk("t6_saturate", cycles, 32'hFFFF_FFFF);
    end
    wait_drain(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
